// File: rtl/adder16_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder16_seq_if : operand request / result handshake bundle for adder16_seq
// Revision: 1.0
// ----------------------------------------------------------------------------
interface adder16_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/adder16_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder16_seq : 16-bit adder sequenced over four passes of an external 5-bit slice
// Revision: 1.0
// ----------------------------------------------------------------------------
module adder16_seq #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 5
) (
  input  wire                clk,
  input  wire                rst,
  adder16_seq_if.slave       bus,
  output logic [SLICE_W-1:0] slice_a,
  output logic [SLICE_W-1:0] slice_b,
  output logic               slice_cin,
  input  wire  [SLICE_W-1:0] slice_sum,
  input  wire                slice_cout
);

  localparam int         PASSES = (WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int         PAD_W  = PASSES * SLICE_W;
  localparam logic [1:0] LAST   = 2'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         pass;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               cin_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic [PAD_W-1:0]   a_pad;
  logic [PAD_W-1:0]   b_pad;

  // Operands are zero-padded so the final pass sees {0000, bit15}
  assign a_pad = {{(PAD_W - WIDTH){1'b0}}, a_reg};
  assign b_pad = {{(PAD_W - WIDTH){1'b0}}, b_reg};

  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_pad[int'(pass) * SLICE_W +: SLICE_W];
      slice_b   = b_pad[int'(pass) * SLICE_W +: SLICE_W];
      slice_cin = (pass == 2'd0) ? cin_reg : carry_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pass      <= 2'd0;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            cin_reg   <= bus.cin;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            pass      <= 2'd0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (pass == LAST) begin
            // Last pass holds bit15 plus padding, so the carry lands in sum bit 1
            sum_reg[WIDTH-1] <= slice_sum[0];
            cout_reg         <= slice_sum[1];
            state            <= DONE;
          end else begin
            sum_reg[int'(pass) * SLICE_W +: SLICE_W] <= slice_sum;
            carry_reg <= slice_cout;
            pass      <= pass + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;

endmodule
`default_nettype wire

// File: doc/adder16_seq.md
# adder16_seq

Multi-cycle 16-bit adder controller that time-multiplexes one external 5-bit slice adder (a[4:0] + b[4:0] + cin -> sum[4:0], cout) over four passes. It registers the operands, drives the slice with one operand field and the running carry per cycle, captures each slice result and assembles the 16-bit sum and carry-out. Exact and approximated slice netlists are interchangeable behind the same slice port, so error can be measured on whole 16-bit words with one slice instance.

## Interface
Parameters:
- WIDTH, 16, operand width (fixed; other values unsupported)
- SLICE_W, 5, slice width; passes = ceil(WIDTH/SLICE_W) = 4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  controller can accept operands
- a  in  16  operand A
- b  in  16  operand B
- cin  in  1  carry-in
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  16  result sum
- cout  out  1  result carry-out
- slice_a  out  5  slice operand A field
- slice_b  out  5  slice operand B field
- slice_cin  out  1  slice carry-in
- slice_sum  in  5  slice sum (combinational from slice_* outputs)
- slice_cout  in  1  slice carry-out

## Operation
- States: IDLE, RUN (pass counter p = 0..3), DONE.
- IDLE: in_ready=1. When in_valid=1, the edge captures a, b, cin into a_reg, b_reg, cin_reg, clears the result register and carry_reg, sets p=0 and enters RUN.
- RUN, pass p: slice_a = a_reg[5p+4:5p] and slice_b = b_reg[5p+4:5p]. Bits above 15 are zero-padded, so pass 3 drives {4'b0, bit15}. slice_cin = cin_reg when p=0, otherwise carry_reg.
- RUN edge, p<3: sum_reg[5p+4:5p] <= slice_sum, carry_reg <= slice_cout, p <= p+1.
- RUN edge, p=3: sum_reg[15] <= slice_sum[0], cout_reg <= slice_sum[1], enter DONE. slice_cout and slice_sum[4:2] are ignored in pass 3.
- DONE: out_valid=1. sum and cout are held stable. When out_ready=1, the edge returns to IDLE.
- Outside RUN, slice_a, slice_b and slice_cin are driven 0.
- in_ready=0 in RUN and DONE. An in_valid asserted there is ignored and not queued.
- No internal arithmetic: every sum and carry bit comes from the slice, so slice error propagates unmodified. With an exact slice, {cout,sum} = a + b + cin.

## Timing
- Reset (asynchronous, any state including mid-RUN): state=IDLE, p=0, a_reg, b_reg, cin_reg, carry_reg, sum_reg and cout_reg all 0. Outputs: in_ready=1, out_valid=0, sum=0, cout=0, slice_* = 0. Any in-flight operation is discarded.
- Accept edge = cycle 0. Passes 0..3 occupy cycles 1..4. out_valid rises after the edge ending cycle 4, so latency is 4 cycles from accept to out_valid.
- out_valid falls on the edge where out_ready=1. in_ready rises on that same edge.
- Minimum interval between accepts is 6 cycles.
- sum and cout are registered and change only on RUN edges and on accept (cleared). They are valid whenever out_valid=1.
- The slice path (slice_* out -> slice_sum/slice_cout in) must settle within one clock period.

## Test plan
- Exact slice model, a=0x1234, b=0x4321, cin=1 -> after 4 cycles out_valid=1, sum=0x5556, cout=0. Per-pass slice_a fields are 0x14, 0x11, 0x04, 0x00.
- Carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x7FFF, b=0, cin=1 -> sum=0x8000, cout=0; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, in_ready stays 0, sum unchanged. A new in_valid pulse is ignored. Raise out_ready -> IDLE on the next edge.
- Reset mid-RUN: assert rst asynchronously during pass 2 -> outputs immediately take their reset values. After release, a new operation 0x0003+0x0004 -> sum=0x0007.
- Slice routing stub: slice returns slice_sum=5'b10101 and slice_cout=1 for every pass -> sum=0xD6B5, cout=0, and slice_cin=1 on passes 1..3.
- Back-to-back with in_valid held high: accepts are exactly 6 cycles apart and results match a randomized 1000-vector exact-slice reference.
